// File: rtl/clkdiv_prog.sv
// clkdiv_prog: runtime-programmable NCH-channel integer clock divider with per-channel ce pulse.
// Optional CLKDIV_ODD_DUTY50_EN: exact 50% duty for odd divisors via a falling-edge flop.
module clkdiv_prog #(
    parameter int NCH = 4,
    parameter int DIV_W = 8,
    parameter int DEFAULT_DIV = 2
) (
    input  logic                    hclkin,
    input  logic                    resetn,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [$clog2(NCH)-1:0]  cfg_ch,
    input  logic [DIV_W-1:0]        cfg_div,
    input  logic [NCH-1:0]          run_en,
    output logic [NCH-1:0]          cfg_pend,
    output logic [NCH-1:0]          clkout,
    output logic [NCH-1:0]          ce
);
    typedef enum logic {STOP, RUN} state_t;

    // High phase of the registered clock term for divisor d at count c; d = 1 never goes high.
    function automatic logic hi(input logic [DIV_W-1:0] d, input logic [DIV_W-1:0] c);
`ifdef CLKDIV_ODD_DUTY50_EN
        return d > DIV_W'(1) && c < (d >> 1);
`else
        return d > DIV_W'(1) && {1'b0, c} < (({1'b0, d} + 1'b1) >> 1);
`endif
    endfunction

    assign cfg_ready = (int'(cfg_ch) < NCH) ? !cfg_pend[cfg_ch] : 1'b1;

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        state_t           st;
        logic [DIV_W-1:0] d_q, s_q, cnt, nd;
        logic             pend, p, ce_q, acc, wrap;
        assign acc = cfg_valid && !pend && (int'(cfg_ch) == g);
        assign wrap = cnt == d_q - 1'b1;
        assign nd = pend ? s_q : d_q;
        always_ff @(posedge hclkin or negedge resetn) begin
            if (!resetn) begin
                st   <= STOP;
                cnt  <= '0;
                d_q  <= DIV_W'(DEFAULT_DIV);
                s_q  <= DIV_W'(DEFAULT_DIV);
                pend <= 1'b0;
                p    <= 1'b0;
                ce_q <= 1'b0;
            end else begin
                if (acc) begin
                    s_q  <= cfg_div;
                    pend <= 1'b1;
                end
                // Divisor swaps and start/stop decisions happen only on a period boundary.
                if (st == STOP || wrap) begin
                    d_q <= nd;
                    if (pend)
                        pend <= 1'b0;
                    cnt <= '0;
                    if (run_en[g] && nd != '0) begin
                        st   <= RUN;
                        p    <= hi(nd, '0);
                        ce_q <= 1'b1;
                    end else begin
                        st   <= STOP;
                        p    <= 1'b0;
                        ce_q <= 1'b0;
                    end
                end else begin
                    cnt  <= cnt + 1'b1;
                    p    <= hi(d_q, cnt + 1'b1);
                    ce_q <= 1'b0;
                end
            end
        end
        assign cfg_pend[g] = pend;
        assign ce[g] = ce_q;
`ifdef CLKDIV_ODD_DUTY50_EN
        logic pn;
        // Half-cycle stretch of the high phase, only for odd divisors of 3 or more.
        always_ff @(negedge hclkin or negedge resetn) begin
            if (!resetn)
                pn <= 1'b0;
            else
                pn <= p && d_q[0] && d_q > DIV_W'(1);
        end
        assign clkout[g] = p | pn;
`else
        assign clkout[g] = p;
`endif
    end
endmodule
